d_pipe_reg: RTL and testbench

Parametrised elastic pipeline register: a chain of DEPTH WIDTH-bit register stages with a per-stage valid bit, valid/ready flow control, bubble collapsing and a synchronous flush. It generalises the single-bit D flip-flop into the standard datapath delay/retiming element used wherever a bus must be delayed or retimed under backpressure. All state uses the synchronous active-high reset.

---
 rtl/d_pipe_reg.sv | 155 +++++++++++++++
 tb/tb_d_pipe_reg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_pipe_reg.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit data, each with a
// valid bit, valid/ready flow control on both ends, same-cycle bubble
// collapsing and a synchronous flush. Stage DEPTH-1 drives the output
// directly, so out_valid/out_data come straight from flops.

// One register stage: holds a word and its valid bit. It loads a new word,
// empties when its word leaves with nothing behind it, or otherwise holds.
module d_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,        // flush (or reset) clears the stage
    input  logic             load,       // a word arrives this cycle
    input  logic [WIDTH-1:0] load_data,
    input  logic             vacate,     // the held word moves on this cycle
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Next-state: clear beats load beats vacate; data is kept when vacating
    // so out_data shows the last word until something replaces it.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr) begin
            v_d = 1'b0;
            d_d = RST_VAL;
        end else if (load) begin
            v_d = 1'b1;
            d_d = load_data;
        end else if (vacate) begin
            v_d = 1'b0;
        end
    end

    // Stage flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= RST_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

module d_pipe_reg #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic [DEPTH-1:0]            move;
    logic                        take_c;
    logic                        clr;
    logic                        in_fire;
    logic                        out_fire;
    logic [OCC_W-1:0]            occ_q, occ_d;

    assign clr = rst | flush;

    // Move chain, walked from the output back to the input. take_c says
    // whether the stage downstream of k can accept a word this cycle: the
    // sink's out_ready for the last stage, else "empty or vacating". Any
    // full stage with room ahead advances, so bubbles close in one cycle.
    always_comb begin
        move   = '0;
        take_c = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            move[k] = v[k] & take_c;
            take_c  = ~v[k] | move[k];
        end
    end

    // in_ready is combinational through the move chain from out_ready, so a
    // full pipe accepts in the same cycle the sink releases it.
    assign in_ready  = ~rst & ~flush & (~v[0] | move[0]);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = v[DEPTH-1] & out_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             load_s;
        logic [WIDTH-1:0] data_s;
        if (g == 0) begin : g_head
            assign load_s = in_fire;
            assign data_s = in_data;
        end else begin : g_body
            assign load_s = move[g-1];
            assign data_s = d[g-1];
        end
        d_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .load      (load_s),
            .load_data (data_s),
            .vacate    (move[g]),
            .v         (v[g]),
            .d         (d[g])
        );
    end

    // Occupancy tracks accepted minus delivered; a flush empties it even if
    // the output handshake fires in the same cycle.
    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_d_pipe_reg.sv
// Directed bench for d_pipe_reg (DEPTH=4, WIDTH=8, RST_VAL=A5) plus a
// randomised DEPTH=1/WIDTH=1 instance checked against a queue model.
module tb_d_pipe_reg;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    logic       flush1, in_valid1, out_ready1, in_data1;
    logic       in_ready1, out_valid1, out_data1;
    logic [0:0] occupancy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_pipe_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    d_pipe_reg #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occupancy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_1 got %b want 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_2 got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'hA5) begin errors++; $display("FAIL rst_out_data got %h want a5", out_data); end
        checks++;
        if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy); end
        checks++;
        if (out_valid1 !== 1'b0 || occupancy1 !== 1'b0) begin
            errors++; $display("FAIL rst_d1 got v=%b occ=%b want 0 0", out_valid1, occupancy1);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            if (i <= 3) begin
                checks++;
                if (out_valid !== 1'b0 || occupancy !== 3'(i)) begin
                    errors++; $display("FAIL stream_fill[%0d] got v=%b occ=%0d want v=0 occ=%0d", i, out_valid, occupancy, i);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'(i - 3) || occupancy !== 3'd4) begin
                    errors++; $display("FAIL stream_out[%0d] got v=%b d=%h occ=%0d want v=1 d=%h occ=4", i, out_valid, out_data, occupancy, 8'(i - 3));
                end
            end
        end
        in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            if (j < 4) begin
                if (out_valid !== 1'b1 || out_data !== 8'(5 + j) || occupancy !== 3'(4 - j)) begin
                    errors++; $display("FAIL stream_drain[%0d] got v=%b d=%h occ=%0d want v=1 d=%h occ=%0d", j, out_valid, out_data, occupancy, 8'(5 + j), 4 - j);
                end
            end else if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
                errors++; $display("FAIL stream_empty got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_w, nxt;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(c);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready[%0d] got %b want 1", c, in_ready); end
            tick();
        end
        in_data = 8'h14;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h10 || occupancy !== 3'd4) begin
                errors++; $display("FAIL bp_stall[%0d] got rdy=%b v=%b d=%h occ=%0d want rdy=0 v=1 d=10 occ=4", c, in_ready, out_valid, out_data, occupancy);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        exp_w = 8'h10; nxt = 8'h14;
        for (int c = 0; c < 20 && exp_w != 8'h16; c++) begin
            in_valid = (nxt <= 8'h15); in_data = nxt;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_w) begin errors++; $display("FAIL bp_order got %h want %h", out_data, exp_w); end
                exp_w++;
            end
            if (in_valid && in_ready) nxt++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (exp_w !== 8'h16 || occupancy !== 3'd0) begin
            errors++; $display("FAIL bp_all_delivered got next=%h occ=%0d want next=16 occ=0", exp_w, occupancy);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h20;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_data = 8'h21;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (occupancy !== 3'd2 || out_valid !== 1'b1 || out_data !== 8'h20 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bubble_packed got occ=%0d v=%b d=%h rdy=%b want occ=2 v=1 d=20 rdy=1", occupancy, out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h21 || occupancy !== 3'd1) begin
            errors++; $display("FAIL bubble_second got v=%b d=%h occ=%0d want v=1 d=21 occ=1", out_valid, out_data, occupancy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL bubble_empty got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 8'h31 + 8'(c);
            tick();
        end
        checks++;
        if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got %0d want 3", occupancy); end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h30;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_input got %b want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'hA5) begin
            errors++; $display("FAIL flush_cleared got occ=%0d v=%b d=%h want occ=0 v=0 d=a5", occupancy, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_word[%0d] got v=%b d=%h want v=0", c, out_valid, out_data); end
            tick();
        end
    endtask

    task automatic test_flush_deliver();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h40;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h40) begin
            errors++; $display("FAIL flushdel_handshake got v=%b d=%h want v=1 d=40", out_valid, out_data);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_data !== 8'hA5) begin
            errors++; $display("FAIL flushdel_empty got v=%b occ=%0d d=%h want v=0 occ=0 d=a5", out_valid, occupancy, out_data);
        end
    endtask

    task automatic test_depth1_random();
        logic q[$];
        int   acc, del;
        logic ifire, ofire;
        acc = 0; del = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid1  = 1'($urandom_range(0, 1));
            in_data1   = 1'($urandom_range(0, 1));
            out_ready1 = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (in_ready1 !== (q.size() == 0 || out_ready1)) begin
                errors++; $display("FAIL d1_in_ready[%0d] got %b want %b", c, in_ready1, (q.size() == 0 || out_ready1));
            end
            checks++;
            if (out_valid1 !== (q.size() != 0)) begin
                errors++; $display("FAIL d1_out_valid[%0d] got %b want %b", c, out_valid1, (q.size() != 0));
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data1 !== q[0]) begin errors++; $display("FAIL d1_out_data[%0d] got %b want %b", c, out_data1, q[0]); end
            end
            checks++;
            if (int'(occupancy1) !== acc - del) begin
                errors++; $display("FAIL d1_occ[%0d] got %0d want %0d", c, occupancy1, acc - del);
            end
            ofire = out_valid1 && out_ready1;
            ifire = in_valid1 && in_ready1;
            if (ofire && q.size() != 0) begin void'(q.pop_front()); del++; end
            if (ifire) begin q.push_back(in_data1); acc++; end
            tick();
        end
        in_valid1 = 1'b0; out_ready1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_flush_deliver();
        test_depth1_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
